ahb_split_ctrl: RTL and testbench

Slave-side SPLIT controller for the 4-master AHB fabric. It sits between a slow slave and the bus. When the slave reports busy, it answers incoming non-locked transfers with a two-cycle SPLIT response and records the requesting master. When the slave frees up, it releases recorded masters to the arbiter one at a time, in arrival order, through HSPLIT pulses. Its Hreadyout/Hresp are this block's contribution only; they are combined externally with the slave's own response (Hreadyout AND-ed, Hresp non-OKAY wins).

---
 rtl/ahb_split_ctrl.sv | 95 +++++++++
 tb/tb_ahb_split_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ahb_split_ctrl.sv
// Slave-side AHB SPLIT controller: splits non-locked transfers while the slave is busy,
// queues the split masters in arrival order and releases them one per cycle via Hsplit.
module ahb_split_ctrl #(
  parameter  int NUM_MASTERS = 4,
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CW  = $clog2(NUM_MASTERS + 1)
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  input  logic                   Hsel,
  input  logic [1:0]             Htrans,
  input  logic                   Hready,
  input  logic [IDW-1:0]         Hmaster,
  input  logic                   Hmastlock,
  input  logic                   slv_busy,
  output logic                   Hreadyout,
  output logic [1:0]             Hresp,
  output logic [NUM_MASTERS-1:0] Hsplit,
  output logic [CW-1:0]          split_pending
);

  typedef enum logic [1:0] {S_IDLE, S_SPLIT1, S_SPLIT2, S_LOCKWAIT} state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  state_t                          state, state_nxt;
  logic                            accept, enq, do_enq, do_pop;
  logic [NUM_MASTERS-1:0][IDW-1:0] fifo;
  logic [IDW-1:0]                  wr_ptr, rd_ptr, head;
  logic [NUM_MASTERS-1:0]          mask, rel_vec;

  assign accept = Hsel && Hready && Htrans[1];
  assign head   = fifo[rd_ptr];

  always_comb begin
    state_nxt = state;
    enq       = 1'b0;
    case (state)
      // SPLIT2 already drives Hreadyout=1, so a new address phase may land here.
      S_IDLE, S_SPLIT2: begin
        state_nxt = S_IDLE;
        if (accept && slv_busy) begin
          if (Hmastlock) state_nxt = S_LOCKWAIT;
          else begin
            state_nxt = S_SPLIT1;
            enq       = 1'b1;
          end
        end
      end
      S_SPLIT1:   state_nxt = S_SPLIT2;
      S_LOCKWAIT: if (!slv_busy) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Enqueue needs slv_busy=1 and pop needs slv_busy=0, so they are exclusive.
  assign do_enq = enq && !mask[Hmaster];
  assign do_pop = !slv_busy && (split_pending != '0);

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_rel
    assign rel_vec[m] = do_pop && (head == IDW'(m));
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state         <= S_IDLE;
      Hreadyout     <= 1'b1;
      Hresp         <= RESP_OKAY;
      Hsplit        <= '0;
      split_pending <= '0;
      fifo          <= '0;
      mask          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      state     <= state_nxt;
      // Outputs registered from next state so they come straight off flops.
      Hreadyout <= !(state_nxt == S_SPLIT1 || state_nxt == S_LOCKWAIT);
      Hresp     <= (state_nxt == S_SPLIT1 || state_nxt == S_SPLIT2) ? RESP_SPLIT : RESP_OKAY;
      Hsplit    <= rel_vec;
      if (do_enq) begin
        fifo[wr_ptr]  <= Hmaster;
        mask[Hmaster] <= 1'b1;
        wr_ptr        <= (wr_ptr == IDW'(NUM_MASTERS - 1)) ? '0 : wr_ptr + IDW'(1);
        split_pending <= split_pending + CW'(1);
      end else if (do_pop) begin
        mask[head]    <= 1'b0;
        rd_ptr        <= (rd_ptr == IDW'(NUM_MASTERS - 1)) ? '0 : rd_ptr + IDW'(1);
        split_pending <= split_pending - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Randomized bench for ahb_split_ctrl against a queue-based model of the split/release rules.
module tb_ahb_split_ctrl;

  logic       Hclk = 1'b0;
  logic       Hresetn;
  logic       Hsel, Hready, Hmastlock, slv_busy;
  logic [1:0] Htrans, Hmaster;
  logic       Hreadyout;
  logic [1:0] Hresp;
  logic [3:0] Hsplit;
  logic [2:0] split_pending;

  ahb_split_ctrl #(.NUM_MASTERS(4)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Htrans(Htrans), .Hready(Hready),
    .Hmaster(Hmaster), .Hmastlock(Hmastlock), .slv_busy(slv_busy),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hsplit(Hsplit), .split_pending(split_pending)
  );

  always #5 Hclk = ~Hclk;

  int checks = 0;
  int errors = 0;

  // Model: pending masters in arrival order, cycles of SPLIT response left, lock stall flag.
  int q[$];
  int split_left;
  bit locked;
  int exp_ready, exp_resp, exp_split;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ready"}, 32'(Hreadyout), 32'(exp_ready));
    chk({tag, "_resp"},  32'(Hresp),     32'(exp_resp));
    chk({tag, "_split"}, 32'(Hsplit),    32'(exp_split));
    chk({tag, "_pend"},  32'(split_pending), 32'(q.size()));
  endtask

  task automatic model_reset();
    q.delete();
    split_left = 0;
    locked     = 1'b0;
    exp_ready  = 1;
    exp_resp   = 0;
    exp_split  = 0;
  endtask

  task automatic drive(input bit sel, input logic [1:0] tr, input bit rdy,
                       input logic [1:0] m, input bit lk, input bit busy);
    Hsel = sel; Htrans = tr; Hready = rdy; Hmaster = m; Hmastlock = lk; slv_busy = busy;
  endtask

  task automatic idle(input bit busy);
    drive(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, busy);
  endtask

  // Advance one clock: model consumes the inputs present before the edge.
  task automatic cyc(input string tag);
    bit acc, free, seen;
    acc  = Hsel && Hready && Htrans[1];
    free = (split_left <= 1) && !locked;
    exp_split = 0;
    if (!slv_busy && q.size() > 0) exp_split = 1 << q.pop_front();
    if (free && acc && slv_busy) begin
      if (Hmastlock) begin
        locked = 1'b1;
        split_left = 0;
      end else begin
        split_left = 2;
        seen = 1'b0;
        foreach (q[i]) if (q[i] == int'(Hmaster)) seen = 1'b1;
        if (!seen) q.push_back(int'(Hmaster));
      end
    end else begin
      if (split_left > 0) split_left--;
      if (locked && !slv_busy) locked = 1'b0;
    end
    exp_ready = (split_left == 2 || locked) ? 0 : 1;
    exp_resp  = (split_left > 0) ? 3 : 0;
    @(posedge Hclk);
    #1;
    check_all(tag);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic pulse_reset(input string tag);
    #2 Hresetn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge Hclk);
    #1 Hresetn = 1'b1;
  endtask

  task automatic split_one(input logic [1:0] m);
    drive(1'b1, 2'b10, 1'b1, m, 1'b0, 1'b1);
    cyc("spl_a");
    idle(1'b1);
    cyc("spl_b");
  endtask

  initial begin
    idle(1'b0);
    Hresetn = 1'b0;
    model_reset();
    #12;
    check_all("rst");
    @(posedge Hclk);
    #1 Hresetn = 1'b1;

    for (int i = 0; i < 5; i++) cyc("idle");

    // Master 2 split, then released
    drive(1'b1, 2'b10, 1'b1, 2'd2, 1'b0, 1'b1);
    cyc("m2_s1");
    chk("m2_s1_const", {Hreadyout, Hresp}, 3'b011);
    idle(1'b1);
    cyc("m2_s2");
    chk("m2_s2_const", {Hreadyout, Hresp, split_pending}, 6'b111_001);
    cyc("m2_hold");
    idle(1'b0);
    cyc("m2_rel");
    chk("m2_rel_const", {Hsplit, split_pending}, 7'b0100_000);
    cyc("m2_after");
    chk("m2_after_const", 32'(Hsplit), 32'd0);

    // Arrival order 3,0,1
    split_one(2'd3); split_one(2'd0); split_one(2'd1);
    chk("ord_pend3", 32'(split_pending), 32'd3);
    idle(1'b0);
    cyc("ord_r0"); chk("ord_r0_const", 32'(Hsplit), 32'b1000);
    cyc("ord_r1"); chk("ord_r1_const", 32'(Hsplit), 32'b0001);
    cyc("ord_r2"); chk("ord_r2_const", 32'(Hsplit), 32'b0010);
    cyc("ord_end");

    // Locked transfer while busy
    drive(1'b1, 2'b10, 1'b1, 2'd1, 1'b1, 1'b1);
    cyc("lk_acc");
    idle(1'b1);
    for (int i = 0; i < 3; i++) cyc("lk_wait");
    chk("lk_const", {Hreadyout, Hresp, split_pending}, 6'b000_000);
    idle(1'b0);
    cyc("lk_exit");
    chk("lk_exit_const", 32'(Hreadyout), 32'd1);

    // Same master twice
    split_one(2'd1); split_one(2'd1);
    chk("dup_pend", 32'(split_pending), 32'd1);
    idle(1'b0);
    cyc("dup_r"); cyc("dup_end"); cyc("dup_end2");

    // Reset mid-release
    split_one(2'd0); split_one(2'd2);
    idle(1'b0);
    cyc("rr_r0");
    pulse_reset("rr_rst");
    for (int i = 0; i < 4; i++) cyc("rr_post");

    // Randomized traffic with sticky busy and occasional resets
    slv_busy = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 4) != 0,
            2'($urandom), $urandom_range(0, 5) == 0,
            ($urandom_range(0, 7) == 0) ? !slv_busy : slv_busy);
      cyc("rnd");
      if ($urandom_range(0, 399) == 0) pulse_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
